cpu_wb_arbiter: RTL



---
 rtl/cpu_wb_pkg.sv | 27 ++
 rtl/rr_arbiter.sv | 47 ++++
 rtl/cpu_wb_arbiter.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/cpu_wb_pkg.sv
// -----------------------------------------------------------------------------
// cpu_wb_pkg
// Shared constants and types for the CPU writeback arbiter slice.
//   DataWidth     : default writeback data width
//   GprAddrWidth  : default general-purpose register address width
//   WbNsrc        : default number of writeback sources
//   wb_src_e      : writeback source indices (ALU, MDU, LSU)
//   ptr_width()   : width of a round-robin pointer for n requesters
// -----------------------------------------------------------------------------
package cpu_wb_pkg;

    localparam int DataWidth    = 32;
    localparam int GprAddrWidth = 5;
    localparam int WbNsrc       = 3;

    typedef enum logic [1:0] {
        WB_ALU = 2'd0,
        WB_MDU = 2'd1,
        WB_LSU = 2'd2
    } wb_src_e;

    // A single requester still needs a 1-bit pointer so port widths stay legal.
    function automatic int ptr_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage : cpu_wb_pkg

// File: rtl/rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
// Purely combinational round-robin grant: the first asserted request at or
// after index ptr, searching upward and wrapping modulo N, receives a one-hot
// grant. No request yields an all-zero grant.
// Ports:
//   req [N-1:0]  in   request vector
//   ptr          in   search start index, must be < N
//   gnt [N-1:0]  out  one-hot grant (all zero when req is zero)
// -----------------------------------------------------------------------------
module rr_arbiter
    import cpu_wb_pkg::*;
#(
    parameter int N = WbNsrc
) (
    input  logic [N-1:0]            req,
    input  logic [ptr_width(N)-1:0] ptr,
    output logic [N-1:0]            gnt
);

    localparam int PW = ptr_width(N);

    logic [PW-1:0] w_idx;
    logic          w_found;

    // Walk the N positions starting at ptr and grant the first requester seen.
    always_comb begin
        gnt     = '0;
        w_found = 1'b0;
        w_idx   = '0;
        for (int k = 0; k < N; k++) begin
            // Modulo-N wrap without a divider.
            if ((int'(ptr) + k) >= N) begin
                w_idx = PW'(int'(ptr) + k - N);
            end else begin
                w_idx = PW'(int'(ptr) + k);
            end
            if (!w_found && req[w_idx]) begin
                gnt[w_idx] = 1'b1;
                w_found    = 1'b1;
            end else begin
                w_found = w_found;
            end
        end
    end

endmodule : rr_arbiter

// File: rtl/cpu_wb_arbiter.sv
// -----------------------------------------------------------------------------
// cpu_wb_arbiter
// Merges NSRC writeback sources onto the single GPR write port using
// round-robin arbitration, registers the winning write for one cycle, and
// keeps a pending-write scoreboard that the issue stage sets and completed
// writebacks clear.
// Ports:
//   clk                        in   rising-edge clock
//   reset_                     in   synchronous reset, asserted when 1
//   src_valid [NSRC-1:0]       in   per-source writeback request
//   src_ready [NSRC-1:0]       out  per-source accept (combinational)
//   src_addr  [NSRC*ADDR-1:0]  in   destination register, source i at [i*ADDR +: ADDR]
//   src_data  [NSRC*DATA-1:0]  in   result, source i at [i*DATA +: DATA]
//   wb_addr   [ADDR-1:0]       out  GPR write address (registered)
//   wb_data   [DATA-1:0]       out  GPR write data (registered)
//   wb_we_                     out  GPR write enable, active-low (registered)
//   iss_set                    in   issue stage marks iss_addr pending
//   iss_addr  [ADDR-1:0]       in   destination being marked
//   busy      [2**ADDR-1:0]    out  pending-write scoreboard (registered)
// -----------------------------------------------------------------------------
module cpu_wb_arbiter
    import cpu_wb_pkg::*;
#(
    parameter int DATA = DataWidth,
    parameter int ADDR = GprAddrWidth,
    parameter int NSRC = WbNsrc
) (
    input  logic                 clk,
    input  logic                 reset_,
    input  logic [NSRC-1:0]      src_valid,
    output logic [NSRC-1:0]      src_ready,
    input  logic [NSRC*ADDR-1:0] src_addr,
    input  logic [NSRC*DATA-1:0] src_data,
    output logic [ADDR-1:0]      wb_addr,
    output logic [DATA-1:0]      wb_data,
    output logic                 wb_we_,
    input  logic                 iss_set,
    input  logic [ADDR-1:0]      iss_addr,
    output logic [2**ADDR-1:0]   busy
);

    localparam int PW   = ptr_width(NSRC);
    localparam int NREG = 2**ADDR;

    logic [PW-1:0]   r_ptr;
    logic [PW-1:0]   w_ptr_nxt;
    logic [NSRC-1:0] w_req;
    logic [NSRC-1:0] w_gnt;
    logic            w_xfer;
    logic [PW-1:0]   w_gidx;
    logic [ADDR-1:0] w_sel_addr;
    logic [DATA-1:0] w_sel_data;
    logic            r_wb_we_n;
    logic [ADDR-1:0] r_wb_addr;
    logic [DATA-1:0] r_wb_data;
    logic [NREG-1:0] r_busy;
    logic [NREG-1:0] w_busy_nxt;

    // Requests are masked during reset so no grant, transfer or scoreboard
    // update can happen on a reset edge.
    assign w_req = reset_ ? {NSRC{1'b0}} : src_valid;

    rr_arbiter #(
        .N (NSRC)
    ) u_rr_arbiter (
        .req (w_req),
        .ptr (r_ptr),
        .gnt (w_gnt)
    );

    assign src_ready = w_gnt;
    assign w_xfer    = |w_gnt;

    // Encode the one-hot grant and select the winning source's address/data.
    always_comb begin
        w_gidx     = '0;
        w_sel_addr = '0;
        w_sel_data = '0;
        for (int i = 0; i < NSRC; i++) begin
            if (w_gnt[i]) begin
                w_gidx     = PW'(i);
                w_sel_addr = src_addr[i*ADDR +: ADDR];
                w_sel_data = src_data[i*DATA +: DATA];
            end else begin
                w_gidx = w_gidx;
            end
        end
    end

    // Pointer moves to the slot after the winner; it holds when idle.
    always_comb begin
        w_ptr_nxt = r_ptr;
        if (!w_xfer) begin
            w_ptr_nxt = r_ptr;
        end else if (w_gidx == PW'(NSRC - 1)) begin
            w_ptr_nxt = '0;
        end else begin
            w_ptr_nxt = w_gidx + PW'(1);
        end
    end

    // Scoreboard next state: clear on writeback first, then apply the issue
    // set so a same-edge set keeps the register pending. Register 0 never
    // becomes pending.
    always_comb begin
        w_busy_nxt = r_busy;
        if (w_xfer) begin
            w_busy_nxt[w_sel_addr] = 1'b0;
        end else begin
            w_busy_nxt = w_busy_nxt;
        end
        if (iss_set) begin
            w_busy_nxt[iss_addr] = 1'b1;
        end else begin
            w_busy_nxt = w_busy_nxt;
        end
        w_busy_nxt[0] = 1'b0;
    end

    // Pointer, scoreboard and registered write port.
    always_ff @(posedge clk) begin
        if (reset_) begin
            r_ptr     <= '0;
            r_busy    <= '0;
            r_wb_we_n <= 1'b1;
            r_wb_addr <= '0;
            r_wb_data <= '0;
        end else begin
            r_ptr     <= w_ptr_nxt;
            r_busy    <= w_busy_nxt;
            // Writes to register 0 are accepted but never reach the GPR file.
            r_wb_we_n <= ~(w_xfer && (w_sel_addr != '0));
            if (w_xfer) begin
                r_wb_addr <= w_sel_addr;
                r_wb_data <= w_sel_data;
            end else begin
                r_wb_addr <= r_wb_addr;
                r_wb_data <= r_wb_data;
            end
        end
    end

    assign wb_we_  = r_wb_we_n;
    assign wb_addr = r_wb_addr;
    assign wb_data = r_wb_data;
    assign busy    = r_busy;

endmodule : cpu_wb_arbiter
